// File: rtl/fifo_narrow.sv
// Width-reducing FIFO: 32-bit words in, 16-bit halves out (low half first).
// Status is derived from the wide-entry count and the half-select bit.
module fifo_narrow #(
    parameter int WIDTH    = 32,
    parameter int DEPTH_P  = 3,
    parameter int DEPTH_P2 = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     data_in,
    input  logic                 put,
    input  logic                 get,
    output logic [WIDTH/2-1:0]   data_out,
    output logic [DEPTH_P+1:0]   fillcount,
    output logic                 empty,
    output logic                 full
);

    localparam int HW = WIDTH / 2;
    localparam logic [DEPTH_P:0] WCOUNT_FULL = (DEPTH_P + 1)'(DEPTH_P2);

    logic [WIDTH-1:0]   mem [DEPTH_P2];

    logic [DEPTH_P-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_P-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_P:0]   wcount_q, wcount_d;
    logic               hsel_q, hsel_d;
    logic [HW-1:0]      data_out_q, data_out_d;

    logic               put_ok;
    logic               get_ok;
    logic [WIDTH-1:0]   rd_word;

    assign empty     = (wcount_q == '0);
    assign full      = (wcount_q == WCOUNT_FULL);
    assign fillcount = {wcount_q, 1'b0} - {{(DEPTH_P + 1){1'b0}}, hsel_q};
    assign data_out  = data_out_q;

    assign put_ok  = put & ~full;
    assign get_ok  = get & ~empty;
    assign rd_word = mem[rd_ptr_q];

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        hsel_d     = hsel_q;
        data_out_d = data_out_q;
        wcount_d   = wcount_q + {{DEPTH_P{1'b0}}, put_ok}
                              - {{DEPTH_P{1'b0}}, get_ok & hsel_q};

        if (put_ok) begin
            wr_ptr_d = wr_ptr_q + DEPTH_P'(1);
        end

        // An entry is only released once its high half has been read.
        if (get_ok) begin
            if (!hsel_q) begin
                data_out_d = rd_word[HW-1:0];
                hsel_d     = 1'b1;
            end else begin
                data_out_d = rd_word[WIDTH-1:HW];
                hsel_d     = 1'b0;
                rd_ptr_d   = rd_ptr_q + DEPTH_P'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            wcount_q   <= '0;
            hsel_q     <= 1'b0;
            data_out_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            wcount_q   <= wcount_d;
            hsel_q     <= hsel_d;
            data_out_q <= data_out_d;
        end
    end

    // Storage is not cleared on reset; the pointers make stale data unreachable.
    always_ff @(posedge clk) begin
        if (put_ok && !reset) begin
            mem[wr_ptr_q] <= data_in;
        end
    end

endmodule
